// File: rtl/shift8_seq.sv
// Sequenced 8-bit shifter/rotator: one bit per cycle for amt steps, then a one-cycle done pulse.
// Requests are accepted only in IDLE; start/op/amt/d_in are ignored while busy.
module shift8_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [2:0] amt,
  input  logic [7:0] d_in,
  output logic [7:0] q,
  output logic       cout,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e     state_q;
  logic [7:0] q_q;
  logic       cout_q;
  logic [2:0] cnt_q;
  logic [2:0] op_q;
  logic [7:0] q_d;
  logic       cout_d;

  // One-bit step of the latched operation, applied while cnt is nonzero.
  always_comb begin
    q_d    = q_q;
    cout_d = cout_q;
    case (op_q)
      OP_LSL: begin q_d = {q_q[6:0], 1'b0};     cout_d = q_q[7]; end
      OP_LSR: begin q_d = {1'b0, q_q[7:1]};     cout_d = q_q[0]; end
      OP_ASR: begin q_d = {q_q[7], q_q[7:1]};   cout_d = q_q[0]; end
      OP_ROL: begin q_d = {q_q[6:0], q_q[7]};   cout_d = q_q[7]; end
      OP_ROR: begin q_d = {q_q[0], q_q[7:1]};   cout_d = q_q[0]; end
      default: begin q_d = q_q;                 cout_d = cout_q; end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      q_q     <= 8'h00;
      cout_q  <= 1'b0;
      cnt_q   <= 3'd0;
      op_q    <= OP_NOP;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_LOAD: begin
                q_q     <= d_in;
                cout_q  <= 1'b0;
                state_q <= DONE;
              end
              OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
                op_q    <= op;
                cnt_q   <= amt;
                state_q <= SHIFT;
              end
              default: state_q <= DONE;  // NOP and reserved code
            endcase
          end
        end
        SHIFT: begin
          if (cnt_q != 3'd0) begin
            q_q    <= q_d;
            cout_q <= cout_d;
            cnt_q  <= cnt_q - 3'd1;
          end else begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q    = q_q;
  assign cout = cout_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift8_seq.sv
// Randomized and directed checks of shift8_seq against a whole-operation arithmetic model.
module tb_shift8_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] op;
  logic [2:0] amt;
  logic [7:0] d_in;
  logic [7:0] q;
  logic       cout;
  logic       busy;
  logic       done;

  int errs   = 0;
  int checks = 0;

  logic [7:0] mq;
  logic       mc;

  shift8_seq dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .amt    (amt),
    .d_in   (d_in),
    .q      (q),
    .cout   (cout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-operation result: {cout, q} after shifting v by n positions in one go.
  function automatic logic [8:0] model(input logic [2:0] o, input logic [2:0] n,
                                       input logic [7:0] v, input logic c);
    logic [15:0] t;
    logic [7:0]  r;
    logic        co;
    r  = v;
    co = c;
    t  = 16'h0;
    case (o)
      3'b010: begin t = {8'h00, v} << n; r = t[7:0];  if (n != 0) co = t[8]; end
      3'b011: begin t = {v, 8'h00} >> n; r = t[15:8]; if (n != 0) co = t[7]; end
      3'b100: begin t = $signed({v, 8'h00}) >>> n; r = t[15:8]; if (n != 0) co = t[7]; end
      3'b101: begin t = {v, v} << n; r = t[15:8]; if (n != 0) co = r[0]; end
      3'b110: begin t = {v, v} >> n; r = t[7:0];  if (n != 0) co = r[7]; end
      default: begin r = v; co = c; end
    endcase
    return {co, r};
  endfunction

  // Issue one request from an IDLE negedge; returns at the first IDLE negedge afterwards.
  task automatic run(input logic [2:0] o, input logic [2:0] n, input logic [7:0] d,
                     input bit inject, input string tag);
    int idx, bcnt, dcnt, didx;
    logic [8:0] r;
    bit is_shift;
    is_shift = (o >= 3'b010) && (o <= 3'b110);
    start = 1'b1; op = o; amt = n; d_in = d;
    @(posedge clk);
    idx = 0; bcnt = 0; dcnt = 0; didx = 0;
    while (idx < 20) begin
      @(negedge clk);
      idx++;
      if (inject) begin
        start = 1'b1; op = 3'b001; amt = 3'd7; d_in = 8'hFF;
      end else begin
        start = 1'b0; op = $urandom_range(0, 7); amt = $urandom_range(0, 7); d_in = $urandom;
      end
      if (busy) bcnt++;
      if (done) begin dcnt++; didx = idx; end
      if (!busy) break;
    end
    start = 1'b0;
    check({tag, " timeout"}, {31'b0, busy}, 32'd0);
    if (o == 3'b001) begin
      mq = d; mc = 1'b0;
    end else begin
      r = model(o, n, mq, mc);
      mq = r[7:0]; mc = r[8];
    end
    check({tag, " q"}, {24'b0, q}, {24'b0, mq});
    check({tag, " cout"}, {31'b0, cout}, {31'b0, mc});
    check({tag, " done_count"}, dcnt, 1);
    check({tag, " done_cycle"}, didx, is_shift ? n + 2 : 1);
    check({tag, " busy_cycles"}, bcnt, is_shift ? n + 2 : 1);
  endtask

  initial begin
    int dcnt;
    reset_n = 1'b0; start = 1'b0; op = 3'b0; amt = 3'b0; d_in = 8'h0;
    mq = 8'h00; mc = 1'b0;
    repeat (2) @(negedge clk);
    check("reset q", {24'b0, q}, 32'h0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset cout", {31'b0, cout}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run(3'b001, 3'd0, 8'hA5, 0, "load_a5");
    check("vec load_a5", {24'b0, q}, 32'hA5);
    run(3'b010, 3'd3, 8'h00, 0, "lsl3");
    check("vec lsl3 q", {24'b0, q}, 32'h28);
    check("vec lsl3 cout", {31'b0, cout}, 32'd1);
    run(3'b001, 3'd0, 8'h96, 0, "load_96a");
    run(3'b100, 3'd2, 8'h00, 0, "asr2");
    check("vec asr2 q", {24'b0, q}, 32'hE5);
    run(3'b001, 3'd0, 8'h96, 0, "load_96b");
    run(3'b011, 3'd2, 8'h00, 0, "lsr2");
    check("vec lsr2 q", {24'b0, q}, 32'h25);
    run(3'b001, 3'd0, 8'h81, 0, "load_81");
    run(3'b110, 3'd7, 8'h00, 0, "ror7");
    check("vec ror7 q", {24'b0, q}, 32'h03);
    run(3'b101, 3'd0, 8'h00, 0, "rol0");
    check("vec rol0 q", {24'b0, q}, 32'h03);
    run(3'b001, 3'd0, 8'h3C, 0, "load_3c");
    run(3'b010, 3'd5, 8'h00, 1, "lsl5_inject");
    check("vec inject q", {24'b0, q}, 32'h80);
    run(3'b000, 3'd4, 8'h55, 0, "nop");
    run(3'b111, 3'd4, 8'h55, 0, "reserved");

    for (int i = 0; i < 40; i++) begin
      run(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom),
          bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    run(3'b001, 3'd0, 8'hC3, 0, "load_c3");
    start = 1'b1; op = 3'b101; amt = 3'd7; d_in = 8'h00;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid busy before reset", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid reset q", {24'b0, q}, 32'h0);
    check("mid reset busy", {31'b0, busy}, 32'd0);
    check("mid reset done", {31'b0, done}, 32'd0);
    check("mid reset cout", {31'b0, cout}, 32'd0);
    dcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("mid reset no done", dcnt, 0);
    mq = 8'h00; mc = 1'b0;
    reset_n = 1'b1;
    run(3'b001, 3'd0, 8'h5A, 0, "load_after_reset");
    run(3'b011, 3'd1, 8'h00, 0, "lsr_after_reset");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
